uart_tx: RTL and testbench

UART transmitter that serialises a parallel word onto a single line as start bit, DATA_WIDTH data bits LSB-first, an optional parity bit and one or two stop bits. It sits between the transceiver's datapath and the `tx` pin, and pairs with the receive block on the same baud settings. It accepts words through a valid/ready handshake and holds no words beyond the one in flight.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_baud_cnt.sv | 27 ++
 rtl/uart_tx.sv | 159 +++++++++++++++
 tb/tb_uart_tx.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, baud divisor and parameter legality helpers.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t IDLE    = 3'd0;
    localparam uart_state_t START   = 3'd1;
    localparam uart_state_t TX_DATA = 3'd2;
    localparam uart_state_t PARITY  = 3'd3;
    localparam uart_state_t STOP    = 3'd4;

    function automatic int clk_per_bit(input int clock_rate, input int baud_rate);
        return clock_rate / baud_rate;
    endfunction

    function automatic bit stop_bits_ok(input int stop_bits);
        return (stop_bits == 1) || (stop_bits == 2);
    endfunction

    function automatic bit data_width_ok(input int data_width);
        return (data_width >= 5) && (data_width <= 9);
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Word handshake between the datapath (master) and the UART transmitter (slave).
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_baud_cnt.sv
// Per-bit clock counter: counts 0..CLK_PER_BIT-1 and strobes tick on the terminal count.
// Synchronous clear holds it at zero; shared by transmitter and receiver.
module uart_baud_cnt #(
    parameter int CLK_PER_BIT = 10
) (
    input  logic clk,
    input  logic arst_n,
    input  logic clear,
    output logic tick
);
    localparam int CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt_reg;

    assign tick = (cnt_reg == CNT_W'(CLK_PER_BIT - 1));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_reg <= '0;
        end else if (clear || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB-first, optional parity, 1 or 2 stop bits.
// Parity is compiled in with the UART_TX_PARITY_EN macro; the default build has no parity bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic     clk,
    input  logic     arst_n,
    uart_tx_if.slave bus,
    output logic     tx,
    output logic     busy,
    output logic     done
);
    localparam int CLK_PER_BIT = clk_per_bit(CLOCK_RATE, BAUD_RATE);
    localparam int BIT_W       = $clog2(DATA_WIDTH);

    if (CLK_PER_BIT < 2) begin : g_rate_check
        $error("uart_tx: CLOCK_RATE/BAUD_RATE must be at least 2");
    end
    if (!data_width_ok(DATA_WIDTH)) begin : g_width_check
        $error("uart_tx: DATA_WIDTH must be 5..9");
    end
    if (!stop_bits_ok(STOP_BITS)) begin : g_stop_check
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_parity_check
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    uart_state_t           state_reg, state_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [BIT_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic                  tx_reg, tx_next;
    logic                  ready_reg, busy_reg;
    logic                  done_reg, done_next;
    logic                  tick, baud_clear;
`ifdef UART_TX_PARITY_EN
    logic                  parity_reg, parity_next;
`endif

    // The baud counter only runs while a frame is on the line, so each state starts at count 0.
    assign baud_clear = (state_reg == IDLE);

    uart_baud_cnt #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_baud_cnt (
        .clk   (clk),
        .arst_n(arst_n),
        .clear (baud_clear),
        .tick  (tick)
    );

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        done_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.valid && ready_reg) begin
                    state_next   = START;
                    shift_next   = bus.data;
                    bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                    parity_next  = (^bus.data) ^ (PARITY_ODD != 0);
`endif
                end
            end
            START: begin
                if (tick) state_next = TX_DATA;
            end
            TX_DATA: begin
                if (tick) begin
                    shift_next = shift_reg >> 1;
                    if (bit_cnt_reg == BIT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) state_next = STOP;
            end
`endif
            STOP: begin
                // bit_cnt is reused to count stop bits
                if (tick) begin
                    if (bit_cnt_reg == BIT_W'(STOP_BITS - 1)) begin
                        bit_cnt_next = '0;
                        state_next   = IDLE;
                        done_next    = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level is derived from the next state so tx comes straight from a flop without lag.
    always_comb begin
        case (state_next)
            START:   tx_next = 1'b0;
            TX_DATA: tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            tx_reg      <= 1'b1;
            ready_reg   <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            tx_reg      <= tx_next;
            ready_reg   <= (state_next == IDLE);
            busy_reg    <= (state_next != IDLE);
            done_reg    <= done_next;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= parity_next;
`endif
        end
    end

    assign tx        = tx_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign bus.ready = ready_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a word scoreboard; covers 1 and 2 stop bits, even/odd parity
// (when UART_TX_PARITY_EN is defined), back-to-back frames, busy-time disturbance and async reset.
module tb_uart_tx;
    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic clk;
    logic arst_n;
    logic tx1, busy1, done1, tx2, busy2, done2;
    logic tx_m, busy_m, done_m, ready_m;
    bit   sel;
    int   cyc, tests, fails;
    logic [7:0] sb[$];

    uart_tx_if #(.DATA_WIDTH(8)) if1 ();
    uart_tx_if #(.DATA_WIDTH(8)) if2 ();

    uart_tx #(.CLOCK_RATE(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
              .STOP_BITS(1), .PARITY_ODD(0))
    dut1 (.clk(clk), .arst_n(arst_n), .bus(if1), .tx(tx1), .busy(busy1), .done(done1));

    uart_tx #(.CLOCK_RATE(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
              .STOP_BITS(2), .PARITY_ODD(1))
    dut2 (.clk(clk), .arst_n(arst_n), .bus(if2), .tx(tx2), .busy(busy2), .done(done2));

    assign tx_m    = sel ? tx2 : tx1;
    assign busy_m  = sel ? busy2 : busy1;
    assign done_m  = sel ? done2 : done1;
    assign ready_m = sel ? if2.ready : if1.ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        if (sel) begin
            if2.valid = v;
            if2.data  = d;
        end else begin
            if1.valid = v;
            if1.data  = d;
        end
    endtask

    task automatic send(input logic [7:0] w, output int acc);
        int n;
        n = 0;
        drive(1'b1, w);
        while (ready_m !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check("send_ready", ready_m, 1);
        acc = cyc;
        tick();
        sb.push_back(w);
        drive(1'b0, w);
        check("lat_tx", tx_m, 0);
        check("lat_ready", ready_m, 0);
        check("lat_busy", busy_m, 1);
        $display("[TB] sent 0x%02h on dut%0d at cycle %0d", w, sel + 1, acc);
    endtask

    task automatic rx_frame(input string tag, output int s, output int d);
        logic [12:0] fb;
        logic [7:0]  w, got_w;
        logic        got_p;
        int          n, nbits, bad, early, stop;
        bit          odd;
        stop = sel ? 2 : 1;
        odd  = sel;
        s = -1;
        d = -1;
        n = 0;
        while (tx_m !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_start"}, tx_m, 0);
        if (tx_m !== 1'b0) return;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s_sb: observed empty scoreboard expected a queued word", tag);
            return;
        end
        w  = sb.pop_front();
        fb = '1;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1 + i] = w[i];
        if (PB == 1) fb[9] = (^w) ^ odd;
        nbits = 9 + PB + stop;
        s = cyc;
        bad = 0;
        early = 0;
        got_w = '0;
        got_p = 1'bx;
        for (int c = 0; c < nbits * CPB; c++) begin
            if (c > 0) tick();
            if (tx_m !== fb[c / CPB]) bad++;
            if (done_m !== 1'b0) early++;
            if (c % CPB == CPB / 2) begin
                if (c / CPB >= 1 && c / CPB <= 8) got_w[c / CPB - 1] = tx_m;
                if (c / CPB == 9) got_p = tx_m;
            end
        end
        tick();
        d = cyc;
        check({tag, "_word"}, got_w, w);
`ifdef UART_TX_PARITY_EN
        check({tag, "_parity"}, got_p, (^w) ^ odd);
`endif
        check({tag, "_wave_bad_cycles"}, bad, 0);
        check({tag, "_early_done"}, early, 0);
        check({tag, "_done"}, done_m, 1);
        check({tag, "_done_tx"}, tx_m, 1);
        check({tag, "_done_ready"}, ready_m, 1);
        check({tag, "_done_busy"}, busy_m, 0);
        $display("[TB] %s: dut%0d word 0x%02h expected 0x%02h start %0d done %0d",
                 tag, sel + 1, got_w, w, s, d);
        tick();
        check({tag, "_done_width"}, done_m, 0);
    endtask

    task automatic quiet(input string tag, input int ncyc);
        int bad;
        bad = 0;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            if (tx_m !== 1'b1 || done_m !== 1'b0 || busy_m !== 1'b0) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        int acc, s0, d0, s1, d1, bad;
        cyc = 0;
        tests = 0;
        fails = 0;
        sel = 1'b0;
        arst_n = 1'b0;
        if1.valid = 1'b0;
        if1.data  = '0;
        if2.valid = 1'b0;
        if2.data  = '0;

        // Reset and idle behaviour
        repeat (3) tick();
        check("rst_tx", tx1, 1);
        check("rst_ready", if1.ready, 1);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        arst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx1 !== 1'b1 || if1.ready !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) bad++;
            if (tx2 !== 1'b1 || if2.ready !== 1'b1 || busy2 !== 1'b0 || done2 !== 1'b0) bad++;
        end
        check("idle_100", bad, 0);

        // Single frames, 1 stop bit, even parity when enabled
        sel = 1'b0;
        send(8'hA5, acc);
        rx_frame("a5_s1", s0, d0);
        check("a5_done_latency", d0 - acc, 1 + (10 + PB) * CPB);
        send(8'h07, acc);
        rx_frame("07_s1", s0, d0);

        // 2 stop bits, odd parity when enabled
        sel = 1'b1;
        send(8'hA5, acc);
        rx_frame("a5_s2", s0, d0);
        send(8'h07, acc);
        rx_frame("07_s2", s0, d0);

        // Back-to-back with valid held high
        drive(1'b1, 8'h3C);
        tick();
        sb.push_back(8'h3C);
        drive(1'b1, 8'hC3);
        sb.push_back(8'hC3);
        rx_frame("b2b_3c", s0, d0);
        drive(1'b0, 8'hC3);
        rx_frame("b2b_c3", s1, d1);
        check("b2b_gap", s1 - d0, 1);
        quiet("b2b_no_extra", 150);
        check("b2b_sb_empty", sb.size(), 0);

        // Data toggling and valid pulse while busy
        sel = 1'b0;
        send(8'h96, acc);
        fork
            rx_frame("hold_96", s0, d0);
            begin
                repeat (20) @(negedge clk);
                if1.valid = 1'b1;
                if1.data  = 8'hFF;
                @(negedge clk);
                if1.valid = 1'b0;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if1.data = 8'($urandom);
                end
            end
        join
        quiet("hold_no_extra", 150);
        check("hold_sb_empty", sb.size(), 0);

        // Asynchronous reset in the middle of the data bits
        send(8'hE1, acc);
        void'(sb.pop_front());
        repeat (35) tick();
        check("abort_busy_before", busy1, 1);
        #2 arst_n = 1'b0;
        #1;
        check("abort_tx", tx1, 1);
        check("abort_busy", busy1, 0);
        check("abort_ready", if1.ready, 1);
        check("abort_done", done1, 0);
        tick();
        tick();
        arst_n = 1'b1;
        quiet("abort_no_done", 150);
        send(8'h5A, acc);
        rx_frame("after_rst_5a", s0, d0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
